spart_tx_arbiter: RTL and testbench

SPART_TX_ARBITER -- requirements
Module: spart_tx_arbiter

---
 rtl/spart_arb_pkg.sv | 30 +++
 rtl/spart_tx_arbiter_if.sv | 35 +++
 rtl/spart_rr_pick.sv | 25 ++
 rtl/spart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_spart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_arb_pkg.sv
// Shared definitions for the SPART transmit arbiter: state encoding, widths, defaults.
// No logic; types and constants only.
// Imported by the interface, the round-robin picker and the arbiter top.
package spart_arb_pkg;

  // Default abandon limit for a word stuck in ISSUE, in cycles
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  // Two requesters share the SPART, so one bit selects a requester
  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned REQ_IDX_W = 1;

  // Width of a transmit word
  localparam int unsigned DATA_W = 24;

  // Timeout counter width covers the full legal TIMEOUT range (up to 65535)
  localparam int unsigned CNT_W = 16;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;
  typedef logic [NUM_REQ-1:0]   req_vec_t;
  typedef logic [DATA_W-1:0]    word_t;

  // The done/err pulse is produced on the ISSUE exit edge, so it needs no state of its own
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_e;

endpackage

// File: rtl/spart_tx_arbiter_if.sv
// Bundle of requester-side and SPART-side signals of the transmit arbiter.
// master = arbiter side (drives SPART select/data and completion pulses).
// slave  = environment side (requesters and SPART controller).
interface spart_tx_arbiter_if;
  import spart_arb_pkg::*;

  // Requester side
  req_vec_t req;
  word_t    req_data0;
  word_t    req_data1;
  req_vec_t done;
  req_vec_t err;

  // SPART controller side
  logic     tx_rdy;
  logic     tx_ack;
  logic     chip_enable;
  logic     r_w;
  word_t    data;

  // Status
  logic     busy;
  req_idx_t owner;

  modport master (
    input  req, req_data0, req_data1, tx_rdy, tx_ack,
    output done, err, chip_enable, r_w, data, busy, owner
  );

  modport slave (
    output req, req_data0, req_data1, tx_rdy, tx_ack,
    input  done, err, chip_enable, r_w, data, busy, owner
  );

endinterface

// File: rtl/spart_rr_pick.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the one not served last.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is taken.
module spart_rr_pick
  import spart_arb_pkg::*;
(
  input  req_vec_t req,
  input  req_idx_t last,
  output logic     valid,
  output req_idx_t idx
);

  // Pick the winner from the request vector and the last-served index
  always_comb begin
    valid = |req;
    idx   = '0;
    unique case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = '0;
    endcase
  end

endmodule

// File: rtl/spart_tx_arbiter.sv
// Arbitrates two requesters onto one SPART transmit port and drives one word per grant.
// Latency: grant edge -> chip_enable next cycle; done/err pulse on the cycle after ack/timeout.
// Backpressure: no grant while tx_rdy is low; ISSUE holds until tx_ack or TIMEOUT cycles elapse.
module spart_tx_arbiter
  import spart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  spart_tx_arbiter_if.master bus
);

  // Counter value on the last ISSUE cycle before the word is abandoned
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  word_t            data_q, data_d;
  req_idx_t         owner_q, owner_d;
  req_idx_t         last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_vec_t         done_q, done_d;
  req_vec_t         err_q, err_d;

  // Low for the first edge after reset release so the earliest grant is one edge later
  logic             arm_q;

  logic             pick_vld;
  req_idx_t         pick_idx;

  spart_rr_pick u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Arm the grant path one edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
    end
  end

  // Next-state and datapath updates; done/err default low so they pulse for one cycle
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm_q && pick_vld && bus.tx_rdy) begin
          state_d = ST_ISSUE;
          owner_d = pick_idx;
          data_d  = pick_idx ? bus.req_data1 : bus.req_data0;
          cnt_d   = '0;
        end
      end

      ST_ISSUE: begin
        // An ack on the final timeout cycle still counts as a successful transfer
        if (bus.tx_ack) begin
          state_d         = ST_WAIT_RDY;
          done_d[owner_q] = 1'b1;
          last_d          = owner_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = ST_WAIT_RDY;
          err_d[owner_q] = 1'b1;
          last_d         = owner_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_RDY: begin
        // Return to IDLE only; a new grant needs a fresh IDLE cycle
        if (bus.tx_rdy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; last_q resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      owner_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registered state so reset drops the select immediately
  assign bus.chip_enable = (state_q == ST_ISSUE);
  assign bus.r_w         = (state_q != ST_ISSUE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.data        = data_q;
  assign bus.owner       = owner_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Self-checking bench for spart_tx_arbiter with a transfer-level reference model.
// Each transfer's winner, word, select length and outcome come from the arbitration rules.
// Directed scenarios first, then a randomized sequence of back-to-back transfers.
module tb_spart_tx_arbiter;

  localparam int TO = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Model state: the requester served last (requester 0 has priority after reset)
  logic m_last;

  spart_tx_arbiter_if bus ();

  spart_tx_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b0;
    bus.req    = 2'b00;
    bus.tx_ack = 1'b0;
    bus.tx_rdy = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    m_last = 1'b1;
  endtask

  // One complete transfer starting from IDLE, ending in IDLE with req = next_rq driven.
  // ack_dly = ISSUE cycle index (0-based) on which tx_ack is driven; >= TO means never.
  task automatic do_xfer(input logic [1:0] rq, input logic [23:0] d0, input logic [23:0] d1,
                         input int ack_dly, input int rdy_wait, input bit drop_req,
                         input logic [1:0] next_rq);
    logic        win;
    logic [23:0] exp_data;
    logic [1:0]  exp_done;
    logic [1:0]  exp_err;
    int          k;
    int          exp_cyc;
    win      = (rq == 2'b11) ? ~m_last : rq[1];
    exp_data = win ? d1 : d0;
    exp_cyc  = (ack_dly < TO) ? ack_dly + 1 : TO;
    exp_done = (ack_dly < TO) ? (2'b01 << win) : 2'b00;
    exp_err  = (ack_dly < TO) ? 2'b00 : (2'b01 << win);

    bus.req       = rq;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    bus.tx_rdy    = 1'b1;
    bus.tx_ack    = 1'b0;
    step();

    checks++;
    if (bus.chip_enable !== 1'b1 || bus.r_w !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL grant_ctl: ce/r_w/busy=%b%b%b expected 101", bus.chip_enable, bus.r_w, bus.busy);
    end
    checks++;
    if (bus.owner !== win) begin
      failures++;
      $display("FAIL grant_owner: got %0d expected %0d", bus.owner, win);
    end
    checks++;
    if (bus.data !== exp_data) begin
      failures++;
      $display("FAIL grant_data: got %06h expected %06h", bus.data, exp_data);
    end

    k = 0;
    while (bus.chip_enable === 1'b1 && k < TO + 4) begin
      checks++;
      if (bus.data !== exp_data || bus.done !== 2'b00 || bus.err !== 2'b00 || bus.r_w !== 1'b0) begin
        failures++;
        $display("FAIL issue_hold: cyc %0d data=%06h done=%b err=%b r_w=%b expected data=%06h done=00 err=00 r_w=0",
                 k, bus.data, bus.done, bus.err, bus.r_w, exp_data);
      end
      bus.tx_ack = (k == ack_dly);
      if (drop_req) bus.req = 2'($urandom_range(0, 3));
      bus.req_data0 = 24'($urandom);
      bus.req_data1 = 24'($urandom);
      k++;
      step();
    end
    bus.tx_ack = 1'b0;

    checks++;
    if (k !== exp_cyc) begin
      failures++;
      $display("FAIL ce_cycles: got %0d expected %0d", k, exp_cyc);
    end
    checks++;
    if (bus.done !== exp_done || bus.err !== exp_err) begin
      failures++;
      $display("FAIL outcome: done=%b err=%b expected done=%b err=%b", bus.done, bus.err, exp_done, exp_err);
    end
    checks++;
    if (bus.r_w !== 1'b1 || bus.busy !== 1'b1 || bus.data !== exp_data || bus.owner !== win) begin
      failures++;
      $display("FAIL release: r_w=%b busy=%b data=%06h owner=%0d expected 1 1 %06h %0d",
               bus.r_w, bus.busy, bus.data, bus.owner, exp_data, win);
    end
    m_last = win;

    bus.req    = next_rq;
    bus.tx_rdy = (rdy_wait == 0);
    for (int w = 0; w < rdy_wait; w++) begin
      step();
      checks++;
      if (bus.busy !== 1'b1 || bus.chip_enable !== 1'b0 || bus.done !== 2'b00 ||
          bus.err !== 2'b00 || bus.data !== exp_data) begin
        failures++;
        $display("FAIL wait_rdy: busy=%b ce=%b done=%b err=%b data=%06h expected 1 0 00 00 %06h",
                 bus.busy, bus.chip_enable, bus.done, bus.err, bus.data, exp_data);
      end
      bus.req_data0 = 24'($urandom);
      bus.req_data1 = 24'($urandom);
      if (w == rdy_wait - 1) bus.tx_rdy = 1'b1;
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.chip_enable !== 1'b0 || bus.done !== 2'b00 ||
        bus.err !== 2'b00 || bus.data !== exp_data) begin
      failures++;
      $display("FAIL back_idle: busy=%b ce=%b done=%b err=%b data=%06h expected 0 0 00 00 %06h",
               bus.busy, bus.chip_enable, bus.done, bus.err, bus.data, exp_data);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.req       = 2'b01;
    bus.tx_rdy    = 1'b1;
    bus.tx_ack    = 1'b0;
    bus.req_data0 = 24'h123456;
    bus.req_data1 = 24'h654321;
    step();
    step();
    checks++;
    if (bus.chip_enable !== 1'b0 || bus.r_w !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: ce/r_w/busy=%b%b%b expected 010", bus.chip_enable, bus.r_w, bus.busy);
    end
    checks++;
    if (bus.data !== 24'h0 || bus.owner !== 1'b0 || bus.done !== 2'b00 || bus.err !== 2'b00) begin
      failures++;
      $display("FAIL reset_dat: data=%06h owner=%0d done=%b err=%b expected 0 0 00 00",
               bus.data, bus.owner, bus.done, bus.err);
    end
    rst    = 1'b1;
    m_last = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.chip_enable !== 1'b0) begin
      failures++;
      $display("FAIL first_edge_grant: busy=%b ce=%b expected 0 0", bus.busy, bus.chip_enable);
    end
    // Second edge after release grants; ack three cycles after chip_enable rises
    do_xfer(2'b01, 24'hA5A5A5, 24'h5A5A5A, 3, 0, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid_issue();
    bus.req       = 2'b01;
    bus.req_data0 = 24'hC0FFEE;
    step();
    step();
    step();
    checks++;
    if (bus.chip_enable !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue_setup: ce=%b expected 1", bus.chip_enable);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.chip_enable !== 1'b0 || bus.r_w !== 1'b1 || bus.busy !== 1'b0 ||
        bus.done !== 2'b00 || bus.err !== 2'b00 || bus.data !== 24'h0) begin
      failures++;
      $display("FAIL async_reset: ce=%b r_w=%b busy=%b done=%b err=%b data=%06h expected 0 1 0 00 00 0",
               bus.chip_enable, bus.r_w, bus.busy, bus.done, bus.err, bus.data);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.done !== 2'b00 || bus.err !== 2'b00 || bus.chip_enable !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_pulse: done=%b err=%b ce=%b expected 00 00 0", bus.done, bus.err, bus.chip_enable);
      end
    end
    rst    = 1'b1;
    m_last = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL regrant_early: busy=%b expected 0", bus.busy);
    end
    do_xfer(2'b01, 24'($urandom), 24'($urandom), 2, 1, 1'b0, 2'b00);
  endtask

  task automatic test_round_robin();
    apply_reset();
    do_xfer(2'b11, 24'h111111, 24'h222222, 1, 0, 1'b0, 2'b11);
    do_xfer(2'b11, 24'h333333, 24'h444444, 0, 0, 1'b0, 2'b00);
  endtask

  task automatic test_timeout();
    do_xfer(2'b01, 24'hDEAD01, 24'hBEEF02, TO + 5, 0, 1'b1, 2'b00);
  endtask

  task automatic test_ack_at_timeout();
    do_xfer(2'b10, 24'h0F0F0F, 24'hF0F0F0, TO - 1, 2, 1'b0, 2'b00);
  endtask

  task automatic test_no_rdy();
    int ce_hi;
    int busy_hi;
    ce_hi      = 0;
    busy_hi    = 0;
    bus.tx_rdy = 1'b0;
    bus.req    = 2'b10;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.chip_enable !== 1'b0) ce_hi++;
      if (bus.busy !== 1'b0) busy_hi++;
    end
    checks++;
    if (ce_hi !== 0 || busy_hi !== 0) begin
      failures++;
      $display("FAIL no_rdy_grant: ce high %0d busy high %0d cycles expected 0 0", ce_hi, busy_hi);
    end
    do_xfer(2'b10, 24'h777777, 24'h888888, 4, 0, 1'b0, 2'b00);
  endtask

  task automatic test_back_to_back_random();
    logic [1:0] rqs[41];
    for (int i = 0; i < 40; i++) rqs[i] = 2'($urandom_range(1, 3));
    rqs[40] = 2'b00;
    for (int i = 0; i < 40; i++) begin
      do_xfer(rqs[i], 24'($urandom), 24'($urandom), int'($urandom_range(0, TO + 2)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rqs[i+1]);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_last     = 1'b1;
    rst        = 1'b1;
    bus.req    = 2'b00;
    bus.tx_rdy = 1'b0;
    bus.tx_ack = 1'b0;
    bus.req_data0 = 24'h0;
    bus.req_data1 = 24'h0;
    #2;
    test_reset();
    test_reset_mid_issue();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_no_rdy();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
